gray_ptr_sync: RTL

Parametrised single-clock-domain synchronizer for Gray-coded async-FIFO pointers, the successor to the fixed two-flop pointer synchronizer in the SDRAM FIFO path. It provides:

- a configurable-depth metastability chain;
- a registered binary decode of the synchronized pointer;
- an advance pulse and per-update pointer delta;
- a sticky error flag for illegal Gray transitions, meaning more than one bit changed between consecutive synchronized samples.

It sits in the read or write domain of each async FIFO, feeding full/empty and level logic.

---
 rtl/gray_ptr_sync_pkg.sv | 29 ++
 rtl/gray_ptr_sync_if.sv | 23 ++
 rtl/gray_ptr_sync_sync_chain.sv | 28 ++
 rtl/gray_ptr_sync.sv | 105 ++++++++++
 4 files changed

// File: rtl/gray_ptr_sync_pkg.sv
// Shared helpers for Gray-coded FIFO pointer synchronizers.
// Functions work on a 32-bit word; callers zero-extend narrower pointers.
package fifo_sync_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int PTR_W_MAX       = 32;

  typedef logic [PTR_W_MAX-1:0] ptr_word_t;

  // Leading zeros from zero-extension leave the prefix XOR unaffected.
  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
    for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic popcount_gt1(input ptr_word_t v);
    return (v & (v - ptr_word_t'(1))) != '0;
  endfunction

endpackage

// File: rtl/gray_ptr_sync_if.sv
// Pointer-sync bundle: source side drives din/err_clr, the synchronizer drives the rest.
interface gray_ptr_sync_if #(
  parameter int W = 3
);
  logic [W-1:0] din;
  logic         err_clr;
  logic [W-1:0] dout;
  logic [W-1:0] dout_bin;
  logic         valid;
  logic         advance;
  logic [W-1:0] delta;
  logic         err;

  modport master (
    output din, err_clr,
    input  dout, dout_bin, valid, advance, delta, err
  );

  modport slave (
    input  din, err_clr,
    output dout, dout_bin, valid, advance, delta, err
  );
endinterface

// File: rtl/gray_ptr_sync_sync_chain.sv
// Plain metastability flop chain; q is the last stage, STAGES edges after d.
// Usable for multi-bit Gray pointers or single-bit control signals.
module sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] s [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        s[i] <= '0;
      end
    end else begin
      s[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        s[i] <= s[i-1];
      end
    end
  end

  assign q = s[STAGES-1];
endmodule

// File: rtl/gray_ptr_sync.sv
// Gray pointer synchronizer: chain, binary decode, advance/delta and sticky illegal-step flag.
// dout lags din by SYNC_STAGES-1 edges after capture; decoded outputs lag one edge more.
module gray_ptr_sync
  import fifo_sync_pkg::*;
#(
  parameter int FIFO_addr_size = 2,
  parameter int SYNC_STAGES    = 2
) (
  input  logic            clk,
  input  logic            rst,
  gray_ptr_sync_if.slave  bus
);
  localparam int W     = FIFO_addr_size + 1;
  localparam int CNT_W = $clog2(SYNC_STAGES_MAX + 1);

  generate
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_depth
      $error("gray_ptr_sync: SYNC_STAGES must be within 2..4");
    end
  endgenerate

  logic [W-1:0]     sync_q;
  logic [W-1:0]     prev_gray;
  logic [W-1:0]     dout_bin_q;
  logic [W-1:0]     delta_q;
  logic [CNT_W-1:0] prime_cnt;
  logic             valid_q;
  logic             advance_q;
  logic             err_q;

  logic [W-1:0]     cur_bin;
  logic [W-1:0]     prev_bin;
  logic             chg;
  logic             illegal;
  logic             primed;

  sync_chain #(
    .WIDTH  (W),
    .STAGES (SYNC_STAGES)
  ) u_chain (
    .clk (clk),
    .rst (rst),
    .d   (bus.din),
    .q   (sync_q)
  );

  always_comb begin
    cur_bin  = W'(gray2bin(PTR_W_MAX'(sync_q)));
    prev_bin = W'(gray2bin(PTR_W_MAX'(prev_gray)));
    chg      = (sync_q != prev_gray);
    illegal  = valid_q && popcount_gt1(PTR_W_MAX'(sync_q ^ prev_gray));
    primed   = (prime_cnt == CNT_W'(SYNC_STAGES));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prime_cnt <= '0;
      valid_q   <= 1'b0;
    end else begin
      if (!primed) begin
        prime_cnt <= prime_cnt + CNT_W'(1);
      end
      valid_q <= primed;
    end
  end

  // Until primed, prev_gray just tracks the chain so a nonzero pointer at
  // reset release is absorbed silently instead of looking like a jump.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_gray  <= '0;
      dout_bin_q <= '0;
      advance_q  <= 1'b0;
      delta_q    <= '0;
    end else begin
      prev_gray  <= sync_q;
      dout_bin_q <= cur_bin;
      if (valid_q && chg) begin
        advance_q <= 1'b1;
        delta_q   <= cur_bin - prev_bin;
      end else begin
        advance_q <= 1'b0;
        delta_q   <= '0;
      end
    end
  end

  // A new illegal step outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (illegal) begin
      err_q <= 1'b1;
    end else if (bus.err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign bus.dout     = sync_q;
  assign bus.dout_bin = dout_bin_q;
  assign bus.valid    = valid_q;
  assign bus.advance  = advance_q;
  assign bus.delta    = delta_q;
  assign bus.err      = err_q;
endmodule
